// File: rtl/receptor_medida_serial_pkg.sv
// Shared types and constants for the 7O1 serial distance receiver.
// Holds the FSM encodings, the ASCII markers and the default bit period.
package receptor_medida_serial_pkg;

    localparam int unsigned CICLOS_BIT_PADRAO = 434;
    localparam int unsigned LARGURA_DADO      = 7;
    localparam int unsigned LARGURA_MEDIDA    = 12;
    localparam int unsigned LARGURA_DB        = 4;

    localparam logic [LARGURA_DADO-1:0] ASCII_HASH = 7'h23;
    localparam logic [LARGURA_DADO-1:0] ASCII_ZERO = 7'h30;

    typedef enum logic [2:0] {
        ESPERA,
        START,
        DADOS,
        PARIDADE,
        STOP,
        FIM
    } estado_rx_t;

    typedef enum logic [LARGURA_DB-1:0] {
        AGUARDA_C    = 4'd0,
        AGUARDA_D    = 4'd1,
        AGUARDA_U    = 4'd2,
        AGUARDA_HASH = 4'd3,
        RESSINC      = 4'd4
    } estado_msg_t;

    // BCD distance, most significant digit first
    typedef struct packed {
        logic [3:0] centena;
        logic [3:0] dezena;
        logic [3:0] unidade;
    } medida_bcd_t;

    function automatic logic eh_digito(input logic [LARGURA_DADO-1:0] c);
        return (c >= ASCII_ZERO) && (c <= (ASCII_ZERO + 7'd9));
    endfunction

endpackage

// File: rtl/receptor_medida_serial_rx.sv
// Character layer: receives 7-bit odd-parity, one-stop-bit characters from a
// synchronized serial line and flags each one as good (dado_pronto) or bad (erro).
module rx_serial_7O1
    import receptor_medida_serial_pkg::*;
#(
    parameter int unsigned CICLOS_BIT = CICLOS_BIT_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    entrada_serial,
    output logic [LARGURA_DADO-1:0] dado_ascii,
    output logic                    dado_pronto,
    output logic                    erro
);

    localparam int unsigned LARGURA_CONT = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
    localparam logic [LARGURA_CONT-1:0] CONT_MEIO = LARGURA_CONT'(CICLOS_BIT / 2);
    localparam logic [LARGURA_CONT-1:0] CONT_BIT  = LARGURA_CONT'(CICLOS_BIT - 1);
    localparam logic [2:0]              ULTIMO_BIT = 3'(LARGURA_DADO - 1);

    logic                    sinc1;
    logic                    linha;
    estado_rx_t              estado,       estado_prox;
    logic [LARGURA_CONT-1:0] contador,     contador_prox;
    logic [2:0]              indice,       indice_prox;
    logic [LARGURA_DADO-1:0] deslocamento, deslocamento_prox;
    logic                    paridade,     paridade_prox;
    logic [LARGURA_DADO-1:0] ascii_prox;
    logic                    pronto_prox;
    logic                    erro_prox;
    logic                    fim_bit;

    // Synchronizer, state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            sinc1        <= 1'b1;
            linha        <= 1'b1;
            estado       <= ESPERA;
            contador     <= '0;
            indice       <= '0;
            deslocamento <= '0;
            paridade     <= 1'b0;
            dado_ascii   <= '0;
            dado_pronto  <= 1'b0;
            erro         <= 1'b0;
        end else begin
            sinc1        <= entrada_serial;
            linha        <= sinc1;
            estado       <= estado_prox;
            contador     <= contador_prox;
            indice       <= indice_prox;
            deslocamento <= deslocamento_prox;
            paridade     <= paridade_prox;
            dado_ascii   <= ascii_prox;
            dado_pronto  <= pronto_prox;
            erro         <= erro_prox;
        end
    end

    // Pulses are registered on the STOP sample so they coincide with FIM
    always_comb begin
        estado_prox       = estado;
        contador_prox     = contador;
        indice_prox       = indice;
        deslocamento_prox = deslocamento;
        paridade_prox     = paridade;
        ascii_prox        = dado_ascii;
        pronto_prox       = 1'b0;
        erro_prox         = 1'b0;
        fim_bit           = (contador == '0);

        case (estado)
            ESPERA: begin
                if (!linha) begin
                    estado_prox   = START;
                    contador_prox = CONT_MEIO;
                end
            end
            START: begin
                if (fim_bit) begin
                    if (!linha) begin
                        estado_prox   = DADOS;
                        contador_prox = CONT_BIT;
                        indice_prox   = '0;
                    end else begin
                        estado_prox = ESPERA;
                    end
                end else begin
                    contador_prox = contador - LARGURA_CONT'(1);
                end
            end
            DADOS: begin
                if (fim_bit) begin
                    deslocamento_prox = {linha, deslocamento[LARGURA_DADO-1:1]};
                    contador_prox     = CONT_BIT;
                    if (indice == ULTIMO_BIT) begin
                        estado_prox = PARIDADE;
                    end else begin
                        indice_prox = indice + 3'd1;
                    end
                end else begin
                    contador_prox = contador - LARGURA_CONT'(1);
                end
            end
            PARIDADE: begin
                if (fim_bit) begin
                    paridade_prox = linha;
                    contador_prox = CONT_BIT;
                    estado_prox   = STOP;
                end else begin
                    contador_prox = contador - LARGURA_CONT'(1);
                end
            end
            STOP: begin
                if (fim_bit) begin
                    estado_prox = FIM;
                    if ((^{deslocamento, paridade}) && linha) begin
                        pronto_prox = 1'b1;
                        ascii_prox  = deslocamento;
                    end else begin
                        erro_prox = 1'b1;
                    end
                end else begin
                    contador_prox = contador - LARGURA_CONT'(1);
                end
            end
            FIM: begin
                estado_prox = ESPERA;
            end
            default: begin
                estado_prox = ESPERA;
            end
        endcase
    end

endmodule

// File: rtl/receptor_medida_serial.sv
// Serial distance receiver: parses "CDU#" frames of ASCII digits from the
// 7O1 character stream and publishes the BCD distance only when a frame is complete.
module receptor_medida_serial
    import receptor_medida_serial_pkg::*;
#(
    parameter int unsigned CICLOS_BIT = CICLOS_BIT_PADRAO
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      entrada_serial,
    output logic [LARGURA_MEDIDA-1:0] medida,
    output logic                      medida_pronto,
    output logic [LARGURA_DADO-1:0]   dado_ascii,
    output logic                      dado_pronto,
    output logic                      erro,
    output logic [LARGURA_DB-1:0]     db_estado
);

    estado_msg_t estado_msg,  estado_msg_prox;
    medida_bcd_t parcial,     parcial_prox;
    medida_bcd_t medida_q,    medida_prox;
    logic        medida_pronto_prox;
    logic        eh_hash;
    logic        digito;

    rx_serial_7O1 #(
        .CICLOS_BIT (CICLOS_BIT)
    ) u_rx (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .dado_ascii     (dado_ascii),
        .dado_pronto    (dado_pronto),
        .erro           (erro)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_msg    <= AGUARDA_C;
            parcial       <= '0;
            medida_q      <= '0;
            medida_pronto <= 1'b0;
        end else begin
            estado_msg    <= estado_msg_prox;
            parcial       <= parcial_prox;
            medida_q      <= medida_prox;
            medida_pronto <= medida_pronto_prox;
        end
    end

    assign medida    = medida_q;
    assign db_estado = estado_msg;

    // Digits accumulate in parcial; medida is only copied on a clean '#'
    always_comb begin
        estado_msg_prox    = estado_msg;
        parcial_prox       = parcial;
        medida_prox        = medida_q;
        medida_pronto_prox = 1'b0;
        eh_hash            = (dado_ascii == ASCII_HASH);
        digito             = eh_digito(dado_ascii);

        if (erro) begin
            estado_msg_prox = RESSINC;
        end else if (dado_pronto) begin
            case (estado_msg)
                AGUARDA_C: begin
                    if (digito) begin
                        parcial_prox.centena = dado_ascii[3:0];
                        estado_msg_prox      = AGUARDA_D;
                    end else if (eh_hash) begin
                        estado_msg_prox = AGUARDA_C;
                    end else begin
                        estado_msg_prox = RESSINC;
                    end
                end
                AGUARDA_D: begin
                    if (digito) begin
                        parcial_prox.dezena = dado_ascii[3:0];
                        estado_msg_prox     = AGUARDA_U;
                    end else if (eh_hash) begin
                        estado_msg_prox = AGUARDA_C;
                    end else begin
                        estado_msg_prox = RESSINC;
                    end
                end
                AGUARDA_U: begin
                    if (digito) begin
                        parcial_prox.unidade = dado_ascii[3:0];
                        estado_msg_prox      = AGUARDA_HASH;
                    end else if (eh_hash) begin
                        estado_msg_prox = AGUARDA_C;
                    end else begin
                        estado_msg_prox = RESSINC;
                    end
                end
                AGUARDA_HASH: begin
                    if (eh_hash) begin
                        medida_prox        = parcial;
                        medida_pronto_prox = 1'b1;
                        estado_msg_prox    = AGUARDA_C;
                    end else begin
                        estado_msg_prox = RESSINC;
                    end
                end
                RESSINC: begin
                    if (eh_hash) begin
                        estado_msg_prox = AGUARDA_C;
                    end
                end
                default: begin
                    estado_msg_prox = AGUARDA_C;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receptor_medida_serial.sv
// Bench for receptor_medida_serial with an 8-cycle bit period: directed frames
// plus random character streams checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_receptor_medida_serial;
    import receptor_medida_serial_pkg::*;

    localparam int unsigned C = 8;

    typedef struct {
        logic [6:0] c;
        bit         bad_par;
        bit         bad_stop;
        int         gap;
    } chr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        entrada_serial = 1'b1;
    logic [11:0] medida;
    logic        medida_pronto;
    logic [6:0]  dado_ascii;
    logic        dado_pronto;
    logic        erro;
    logic [3:0]  db_estado;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [6:0]  seg[$];
    bit          poison;
    int          exp_dado, exp_erro;
    logic [11:0] exp_q[$];
    logic [11:0] exp_medida;
    logic [6:0]  exp_ascii;

    // Observations (written only by the monitor)
    int          n_dado = 0, n_erro = 0, n_hold_bad = 0;
    logic [11:0] mp_val[$];
    bit          mp_lat[$];
    logic        prev_dado = 1'b0, prev_reset = 1'b1;
    logic [6:0]  prev_ascii = '0;
    logic [11:0] prev_medida = '0;

    int b_dado, b_erro, b_mp, b_hold;
    chr_t seq[$];

    receptor_medida_serial #(.CICLOS_BIT(C)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .medida         (medida),
        .medida_pronto  (medida_pronto),
        .dado_ascii     (dado_ascii),
        .dado_pronto    (dado_pronto),
        .erro           (erro),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (dado_pronto === 1'b1) n_dado++;
        if (erro === 1'b1) n_erro++;
        if (medida_pronto === 1'b1) begin
            mp_val.push_back(medida);
            mp_lat.push_back(prev_dado && (prev_ascii == 7'h23));
        end
        if (!reset && !prev_reset && (medida !== prev_medida) && (medida_pronto !== 1'b1))
            n_hold_bad++;
        prev_dado   = dado_pronto;
        prev_ascii  = dado_ascii;
        prev_medida = medida;
        prev_reset  = reset;
    end

    function automatic chr_t ch(input logic [6:0] c, input bit bp = 1'b0,
                                input bit bs = 1'b0, input int g = 1);
        chr_t x;
        x.c = c; x.bad_par = bp; x.bad_stop = bs; x.gap = g;
        return x;
    endfunction

    function automatic bit is_digit(input logic [6:0] c);
        return (c >= 7'h30) && (c <= 7'h39);
    endfunction

    task automatic mark();
        seg.delete();
        poison     = 1'b0;
        exp_dado   = 0;
        exp_erro   = 0;
        exp_q.delete();
        exp_medida = '0;
        exp_ascii  = '0;
        b_dado = n_dado;
        b_erro = n_erro;
        b_mp   = mp_val.size();
        b_hold = n_hold_bad;
    endtask

    // Frame rule: a '#' publishes iff the chars since the last '#' are exactly 3 digits with no error
    task automatic model_char(input chr_t x);
        if (x.bad_par || x.bad_stop) begin
            exp_erro++;
            poison = 1'b1;
        end else begin
            exp_dado++;
            exp_ascii = x.c;
            if (x.c == 7'h23) begin
                if (!poison && seg.size() == 3 &&
                    is_digit(seg[0]) && is_digit(seg[1]) && is_digit(seg[2])) begin
                    exp_medida = {seg[0][3:0], seg[1][3:0], seg[2][3:0]};
                    exp_q.push_back(exp_medida);
                end
                seg.delete();
                poison = 1'b0;
            end else begin
                seg.push_back(x.c);
            end
        end
    endtask

    task automatic send_char(input chr_t x);
        logic [9:0] quadro;
        quadro = {~x.bad_stop, (~^x.c) ^ x.bad_par, x.c, 1'b0};
        for (int i = 0; i < 10; i++) begin
            entrada_serial = quadro[i];
            repeat (C) @(negedge clock);
        end
        entrada_serial = 1'b1;
        repeat (x.gap * C) @(negedge clock);
    endtask

    task automatic play(input chr_t s[$]);
        foreach (s[i]) begin
            model_char(s[i]);
            send_char(s[i]);
        end
        repeat (3 * C) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        entrada_serial = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        mark();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (medida !== 12'h000) begin bad++; $display("FAIL reset_medida: got %h expected 000", medida); end
        total++; if (medida_pronto !== 1'b0) begin bad++; $display("FAIL reset_medida_pronto: got %b expected 0", medida_pronto); end
        total++; if (dado_ascii !== 7'h00) begin bad++; $display("FAIL reset_dado_ascii: got %h expected 00", dado_ascii); end
        total++; if (dado_pronto !== 1'b0) begin bad++; $display("FAIL reset_dado_pronto: got %b expected 0", dado_pronto); end
        total++; if (erro !== 1'b0) begin bad++; $display("FAIL reset_erro: got %b expected 0", erro); end
        total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL reset_db_estado: got %0d expected 0", db_estado); end
    endtask

    task automatic test_frame_valido();
        do_reset();
        seq.delete();
        seq.push_back(ch(7'h31)); seq.push_back(ch(7'h32));
        seq.push_back(ch(7'h33)); seq.push_back(ch(7'h23));
        play(seq);
        total++; if (n_dado - b_dado !== 4) begin bad++; $display("FAIL valido_dado_count: got %0d expected 4", n_dado - b_dado); end
        total++; if (n_erro - b_erro !== 0) begin bad++; $display("FAIL valido_erro_count: got %0d expected 0", n_erro - b_erro); end
        total++; if (mp_val.size() - b_mp !== 1) begin bad++; $display("FAIL valido_mp_count: got %0d expected 1", mp_val.size() - b_mp); end
        total++; if (medida !== 12'h123) begin bad++; $display("FAIL valido_medida: got %h expected 123", medida); end
        if (mp_val.size() > b_mp) begin
            total++; if (!mp_lat[b_mp]) begin bad++; $display("FAIL valido_latency: medida_pronto not one cycle after '#' dado_pronto"); end
        end
        total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL valido_db_estado: got %0d expected 0", db_estado); end
    endtask

    task automatic test_paridade();
        do_reset();
        seq.delete();
        seq.push_back(ch(7'h34, 1'b1)); seq.push_back(ch(7'h35));
        seq.push_back(ch(7'h36));       seq.push_back(ch(7'h23));
        play(seq);
        total++; if (n_erro - b_erro !== 1) begin bad++; $display("FAIL paridade_erro_count: got %0d expected 1", n_erro - b_erro); end
        total++; if (medida !== 12'h000) begin bad++; $display("FAIL paridade_medida_hold: got %h expected 000", medida); end
        total++; if (mp_val.size() - b_mp !== 0) begin bad++; $display("FAIL paridade_no_mp: got %0d expected 0", mp_val.size() - b_mp); end
        total++; if (dado_ascii !== 7'h23) begin bad++; $display("FAIL paridade_ascii: got %h expected 23", dado_ascii); end
        seq.delete();
        seq.push_back(ch(7'h37)); seq.push_back(ch(7'h38));
        seq.push_back(ch(7'h39)); seq.push_back(ch(7'h23));
        play(seq);
        total++; if (medida !== 12'h789) begin bad++; $display("FAIL paridade_medida: got %h expected 789", medida); end
        total++; if (mp_val.size() - b_mp !== 1) begin bad++; $display("FAIL paridade_mp_count: got %0d expected 1", mp_val.size() - b_mp); end
        total++; if (n_erro - b_erro !== exp_erro) begin bad++; $display("FAIL paridade_erro_total: got %0d expected %0d", n_erro - b_erro, exp_erro); end
    endtask

    task automatic test_glitch();
        do_reset();
        entrada_serial = 1'b0;
        repeat (3) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (3 * C) @(negedge clock);
        total++; if (n_dado - b_dado !== 0) begin bad++; $display("FAIL glitch_dado: got %0d expected 0", n_dado - b_dado); end
        total++; if (n_erro - b_erro !== 0) begin bad++; $display("FAIL glitch_erro: got %0d expected 0", n_erro - b_erro); end
        total++; if (dut.u_rx.estado !== ESPERA) begin bad++; $display("FAIL glitch_estado: got %0d expected %0d", dut.u_rx.estado, ESPERA); end
    endtask

    task automatic test_nao_digito();
        do_reset();
        seq.delete();
        seq.push_back(ch(7'h41)); seq.push_back(ch(7'h23));
        seq.push_back(ch(7'h30)); seq.push_back(ch(7'h34));
        seq.push_back(ch(7'h32)); seq.push_back(ch(7'h23));
        play(seq);
        total++; if (n_erro - b_erro !== 0) begin bad++; $display("FAIL naodig_erro: got %0d expected 0", n_erro - b_erro); end
        total++; if (medida !== 12'h042) begin bad++; $display("FAIL naodig_medida: got %h expected 042", medida); end
        total++; if (mp_val.size() - b_mp !== 1) begin bad++; $display("FAIL naodig_mp_count: got %0d expected 1", mp_val.size() - b_mp); end
    endtask

    task automatic test_reset_meio();
        int d0;
        do_reset();
        seq.delete();
        seq.push_back(ch(7'h35)); seq.push_back(ch(7'h35));
        seq.push_back(ch(7'h35)); seq.push_back(ch(7'h23));
        play(seq);
        total++; if (medida !== 12'h555) begin bad++; $display("FAIL rstmeio_pre_medida: got %h expected 555", medida); end
        d0 = n_dado + n_erro;
        fork
            send_char(ch(7'h39));
            begin
                repeat (4 * C + C / 2) @(negedge clock);
                reset = 1'b1;
            end
        join
        total++; if (n_dado + n_erro !== d0) begin bad++; $display("FAIL rstmeio_pulse: got %0d pulses expected 0", n_dado + n_erro - d0); end
        total++; if (medida !== 12'h000) begin bad++; $display("FAIL rstmeio_medida0: got %h expected 000", medida); end
        total++; if (dado_ascii !== 7'h00) begin bad++; $display("FAIL rstmeio_ascii0: got %h expected 00", dado_ascii); end
        total++; if ({medida_pronto, dado_pronto, erro} !== 3'b000) begin bad++; $display("FAIL rstmeio_pulses0: got %b expected 000", {medida_pronto, dado_pronto, erro}); end
        total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL rstmeio_db0: got %0d expected 0", db_estado); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        mark();
        seq.delete();
        seq.push_back(ch(7'h31)); seq.push_back(ch(7'h30));
        seq.push_back(ch(7'h30)); seq.push_back(ch(7'h23));
        play(seq);
        total++; if (medida !== 12'h100) begin bad++; $display("FAIL rstmeio_medida: got %h expected 100", medida); end
        total++; if (n_dado - b_dado !== 4) begin bad++; $display("FAIL rstmeio_dado_count: got %0d expected 4", n_dado - b_dado); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        seq.delete();
        seq.push_back(ch(7'h31, 0, 0, 0)); seq.push_back(ch(7'h32, 0, 0, 0));
        seq.push_back(ch(7'h33, 0, 0, 0)); seq.push_back(ch(7'h23, 0, 0, 0));
        seq.push_back(ch(7'h34, 0, 0, 0)); seq.push_back(ch(7'h35, 0, 0, 0));
        seq.push_back(ch(7'h36, 0, 0, 0)); seq.push_back(ch(7'h23, 0, 0, 0));
        play(seq);
        total++; if (n_erro - b_erro !== 0) begin bad++; $display("FAIL b2b_erro: got %0d expected 0", n_erro - b_erro); end
        total++; if (n_dado - b_dado !== 8) begin bad++; $display("FAIL b2b_dado: got %0d expected 8", n_dado - b_dado); end
        total++; if (mp_val.size() - b_mp !== exp_q.size()) begin bad++; $display("FAIL b2b_mp_count: got %0d expected %0d", mp_val.size() - b_mp, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && b_mp + i < mp_val.size(); i++) begin
            total++; if (mp_val[b_mp + i] !== exp_q[i]) begin bad++; $display("FAIL b2b_mp_value[%0d]: got %h expected %h", i, mp_val[b_mp + i], exp_q[i]); end
        end
        total++; if (medida !== 12'h456) begin bad++; $display("FAIL b2b_medida: got %h expected 456", medida); end
    endtask

    task automatic test_aleatorio();
        int r;
        do_reset();
        for (int round = 0; round < 3; round++) begin
            seq.delete();
            for (int k = 0; k < 14; k++) begin
                chr_t x;
                r = $urandom_range(0, 9);
                if (r < 6)      x.c = 7'(32'h30 + $urandom_range(0, 9));
                else if (r < 8) x.c = 7'h23;
                else            x.c = 7'(32'h41 + $urandom_range(0, 25));
                x.bad_par  = ($urandom_range(0, 11) == 0);
                x.bad_stop = !x.bad_par && ($urandom_range(0, 14) == 0);
                x.gap      = x.bad_stop ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
                seq.push_back(x);
                if ($urandom_range(0, 1) == 1) begin
                    for (int j = 0; j < 3; j++) seq.push_back(ch(7'(32'h30 + $urandom_range(0, 9)), 0, 0, $urandom_range(0, 1)));
                    seq.push_back(ch(7'h23, 0, 0, $urandom_range(0, 2)));
                end
            end
            play(seq);
        end
        total++; if (n_dado - b_dado !== exp_dado) begin bad++; $display("FAIL rand_dado: got %0d expected %0d", n_dado - b_dado, exp_dado); end
        total++; if (n_erro - b_erro !== exp_erro) begin bad++; $display("FAIL rand_erro: got %0d expected %0d", n_erro - b_erro, exp_erro); end
        total++; if (mp_val.size() - b_mp !== exp_q.size()) begin bad++; $display("FAIL rand_mp_count: got %0d expected %0d", mp_val.size() - b_mp, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && b_mp + i < mp_val.size(); i++) begin
            total++; if (mp_val[b_mp + i] !== exp_q[i]) begin bad++; $display("FAIL rand_mp_value[%0d]: got %h expected %h", i, mp_val[b_mp + i], exp_q[i]); end
            total++; if (!mp_lat[b_mp + i]) begin bad++; $display("FAIL rand_latency[%0d]: medida_pronto not one cycle after '#'", i); end
        end
        total++; if (medida !== exp_medida) begin bad++; $display("FAIL rand_medida: got %h expected %h", medida, exp_medida); end
        total++; if (dado_ascii !== exp_ascii) begin bad++; $display("FAIL rand_ascii: got %h expected %h", dado_ascii, exp_ascii); end
        total++; if (n_hold_bad !== 0) begin bad++; $display("FAIL medida_hold: got %0d silent changes expected 0", n_hold_bad); end
    endtask

    initial begin
        test_reset();
        test_frame_valido();
        test_paridade();
        test_glitch();
        test_nao_digito();
        test_reset_meio();
        test_back_to_back();
        test_aleatorio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
